// File: rtl/mips_wb_select.sv
// MEM/WB writeback-select stage: picks ALU, extracted load, LUI or link data
// and holds it in a stall/flush-aware pipeline register.
module mips_wb_select #(
    parameter int NBITS      = 32,
    parameter int NREG_BITS  = 5,
    localparam int NLANE_BITS = $clog2(NBITS / 8)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_valid,
    input  logic                  i_stall,
    input  logic                  i_flush,
    input  logic [1:0]            i_wb_sel,
    input  logic [1:0]            i_load_size,
    input  logic                  i_load_unsigned,
    input  logic [NLANE_BITS-1:0] i_addr_lo,
    input  logic [NBITS-1:0]      i_mem_data,
    input  logic [NBITS-1:0]      i_alu_result,
    input  logic [15:0]           i_imm16,
    input  logic [NBITS-1:0]      i_pc_plus8,
    input  logic [NREG_BITS-1:0]  i_rd,
    input  logic                  i_reg_write,
    output logic [NBITS-1:0]      o_wb_data,
    output logic [NREG_BITS-1:0]  o_wb_reg,
    output logic                  o_wb_en,
    output logic                  o_valid,
    output logic                  o_misaligned
);

    function automatic logic [NBITS-1:0] f_ext8(input logic [7:0] v, input logic uns);
        f_ext8 = {{(NBITS-8){~uns & v[7]}}, v};
    endfunction

    function automatic logic [NBITS-1:0] f_ext16(input logic [15:0] v, input logic uns);
        f_ext16 = {{(NBITS-16){~uns & v[15]}}, v};
    endfunction

    logic [NLANE_BITS-2:0] w_half_lane;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [NBITS-1:0]      w_load_data;
    logic [NBITS-1:0]      w_lui_data;
    logic                  w_misaligned;
    logic [NBITS-1:0]      w_next_data;
    logic                  w_wb_en;

    logic [NBITS-1:0]      r_wb_data;
    logic [NREG_BITS-1:0]  r_wb_reg;
    logic                  r_wb_en;
    logic                  r_valid;
    logic                  r_misaligned;

    assign w_half_lane = i_addr_lo[NLANE_BITS-1:1];
    assign w_byte      = i_mem_data[{i_addr_lo, 3'b000} +: 8];
    assign w_half      = i_mem_data[{w_half_lane, 4'b0000} +: 16];
    // Sign-extending the immediate first and then shifting keeps bit 31 replicated above 32 bits.
    assign w_lui_data  = f_ext16(i_imm16, 1'b0) << 16;

    // Load lane extraction and alignment check
    always_comb begin
        w_load_data  = i_mem_data;
        w_misaligned = 1'b0;
        case (i_load_size)
            2'd0: begin
                w_load_data  = f_ext8(w_byte, i_load_unsigned);
                w_misaligned = 1'b0;
            end
            2'd1: begin
                w_load_data  = f_ext16(w_half, i_load_unsigned);
                w_misaligned = i_addr_lo[0];
            end
            default: begin
                w_load_data  = i_mem_data;
                w_misaligned = |i_addr_lo;
            end
        endcase
        if (i_wb_sel != 2'd1) begin
            w_misaligned = 1'b0;
        end else begin
            w_misaligned = w_misaligned;
        end
    end

    // Writeback source select
    always_comb begin
        w_next_data = i_alu_result;
        case (i_wb_sel)
            2'd0:    w_next_data = i_alu_result;
            2'd1:    w_next_data = w_misaligned ? {NBITS{1'b0}} : w_load_data;
            2'd2:    w_next_data = w_lui_data;
            2'd3:    w_next_data = i_pc_plus8;
            default: w_next_data = i_alu_result;
        endcase
    end

    assign w_wb_en = i_valid & i_reg_write & (i_rd != {NREG_BITS{1'b0}}) & ~w_misaligned;

    // Pipeline register: reset and flush load a bubble, stall holds
    always_ff @(posedge i_clk) begin
        if (!i_reset || i_flush) begin
            r_wb_data    <= {NBITS{1'b0}};
            r_wb_reg     <= {NREG_BITS{1'b0}};
            r_wb_en      <= 1'b0;
            r_valid      <= 1'b0;
            r_misaligned <= 1'b0;
        end else if (!i_stall) begin
            r_wb_data    <= w_next_data;
            r_wb_reg     <= i_rd;
            r_wb_en      <= w_wb_en;
            r_valid      <= i_valid;
            r_misaligned <= i_valid & w_misaligned;
        end
    end

    assign o_wb_data    = r_wb_data;
    assign o_wb_reg     = r_wb_reg;
    assign o_wb_en      = r_wb_en;
    assign o_valid      = r_valid;
    assign o_misaligned = r_misaligned;

endmodule

// File: tb/tb_mips_wb_select.sv
// Scoreboard bench for mips_wb_select: directed cases followed by random traffic,
// each checked against a behavioural model of the writeback rules.
module tb_mips_wb_select;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, stall, flush, uns, rw;
    logic [1:0]  sel, size, addr;
    logic [31:0] mem, alu, pc8;
    logic [15:0] imm;
    logic [4:0]  rd;
    logic [31:0] wb_data;
    logic [4:0]  wb_reg;
    logic        wb_en, o_vld, mis;

    typedef struct {
        logic        rst, valid, stall, flush, uns, rw;
        logic [1:0]  sel, size, addr;
        logic [31:0] mem, alu, pc8;
        logic [15:0] imm;
        logic [4:0]  rd;
    } stim_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rg;
        logic        en, vld, mis, chk_data;
    } exp_t;

    exp_t model;
    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    mips_wb_select dut (
        .i_clk(clk), .i_reset(rst_n), .i_valid(valid), .i_stall(stall), .i_flush(flush),
        .i_wb_sel(sel), .i_load_size(size), .i_load_unsigned(uns), .i_addr_lo(addr),
        .i_mem_data(mem), .i_alu_result(alu), .i_imm16(imm), .i_pc_plus8(pc8),
        .i_rd(rd), .i_reg_write(rw),
        .o_wb_data(wb_data), .o_wb_reg(wb_reg), .o_wb_en(wb_en),
        .o_valid(o_vld), .o_misaligned(mis)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
        end
    endtask

    function automatic exp_t bubble();
        exp_t e;
        e.data = 32'd0; e.rg = 5'd0; e.en = 1'b0; e.vld = 1'b0; e.mis = 1'b0; e.chk_data = 1'b1;
        return e;
    endfunction

    // Reference: writeback value and alignment from plain shifts and masks.
    function automatic exp_t next_model(input exp_t cur, input stim_t s);
        exp_t        e;
        logic [31:0] v;
        logic        bad;
        if (!s.rst || s.flush) return bubble();
        if (s.stall) return cur;
        bad = 1'b0;
        case (s.sel)
            2'd0: v = s.alu;
            2'd2: v = {16'd0, s.imm} << 16;
            2'd3: v = s.pc8;
            default: begin
                if (s.size == 2'd0) begin
                    v = (s.mem >> (s.addr * 8)) & 32'hFF;
                    if (!s.uns && v >= 32'd128) v = v | 32'hFFFF_FF00;
                end else if (s.size == 2'd1) begin
                    v = (s.mem >> ((s.addr / 2) * 16)) & 32'hFFFF;
                    if (!s.uns && v >= 32'd32768) v = v | 32'hFFFF_0000;
                    bad = (s.addr % 2) == 1;
                end else begin
                    v = s.mem;
                    bad = s.addr != 2'd0;
                end
                if (bad) v = 32'd0;
            end
        endcase
        e.data     = v;
        e.rg       = s.rd;
        e.en       = s.valid && s.rw && (s.rd != 5'd0) && !bad;
        e.vld      = s.valid;
        e.mis      = s.valid && bad;
        e.chk_data = s.valid;
        return e;
    endfunction

    function automatic stim_t base(input logic [1:0] s_sel, input logic [4:0] s_rd);
        stim_t s;
        s.rst = 1'b1; s.valid = 1'b1; s.stall = 1'b0; s.flush = 1'b0; s.uns = 1'b0; s.rw = 1'b1;
        s.sel = s_sel; s.size = 2'd2; s.addr = 2'd0;
        s.mem = 32'd0; s.alu = 32'd0; s.pc8 = 32'd0; s.imm = 16'd0; s.rd = s_rd;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst   = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
        s.valid = ($urandom_range(0, 9) < 8);
        s.stall = ($urandom_range(0, 99) < 20);
        s.flush = ($urandom_range(0, 99) < 8);
        s.uns   = 1'($urandom);
        s.rw    = ($urandom_range(0, 9) < 8);
        s.sel   = 2'($urandom);
        s.size  = 2'($urandom);
        s.addr  = 2'($urandom);
        s.mem   = $urandom;
        s.alu   = $urandom;
        s.pc8   = $urandom;
        s.imm   = 16'($urandom);
        s.rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        return s;
    endfunction

    task automatic apply(input stim_t s);
        @(negedge clk);
        rst_n = s.rst; valid = s.valid; stall = s.stall; flush = s.flush; uns = s.uns;
        rw = s.rw; sel = s.sel; size = s.size; addr = s.addr; mem = s.mem; alu = s.alu;
        pc8 = s.pc8; imm = s.imm; rd = s.rd;
        model = next_model(model, s);
        q.push_back(model);
    endtask

    // Monitor: one expected entry per clock edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("o_valid", {31'd0, o_vld}, {31'd0, e.vld});
                chk("o_wb_en", {31'd0, wb_en}, {31'd0, e.en});
                chk("o_misaligned", {31'd0, mis}, {31'd0, e.mis});
                chk("o_wb_reg", {27'd0, wb_reg}, {27'd0, e.rg});
                if (e.chk_data) chk("o_wb_data", wb_data, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        stim_t s;
        model = bubble();
        rst_n = 1'b0; valid = 1'b0; stall = 1'b0; flush = 1'b0; uns = 1'b0; rw = 1'b0;
        sel = 2'd0; size = 2'd0; addr = 2'd0; mem = 32'd0; alu = 32'd0; pc8 = 32'd0;
        imm = 16'd0; rd = 5'd0;

        for (int i = 0; i < 2; i++) begin
            s = rand_stim(); s.rst = 1'b0; apply(s);
        end
        s = base(2'd0, 5'd0); s.valid = 1'b0; apply(s);

        s = base(2'd1, 5'd5); s.mem = 32'h8081_F2F3; s.size = 2'd0; s.addr = 2'd1; apply(s);
        s.uns = 1'b1; apply(s);
        s.uns = 1'b0; s.size = 2'd1; s.addr = 2'd2; apply(s);
        s.size = 2'd2; s.addr = 2'd0; apply(s);

        s = base(2'd2, 5'd5); s.imm = 16'hABCD; apply(s);
        s = base(2'd3, 5'd5); s.pc8 = 32'h0040_0108; apply(s);
        s = base(2'd0, 5'd5); s.alu = 32'h1234_5678; apply(s);

        s = base(2'd1, 5'd7); s.mem = 32'hDEAD_BEEF; s.size = 2'd1; s.addr = 2'd3; apply(s);
        s.size = 2'd2; s.addr = 2'd2; apply(s);
        s.addr = 2'd0; apply(s);

        s = base(2'd0, 5'd0); s.alu = 32'h5; apply(s);

        s = base(2'd0, 5'd9); s.alu = 32'h0000_0011; apply(s);
        for (int i = 0; i < 3; i++) begin
            s = rand_stim(); s.rst = 1'b1; s.stall = 1'b1; s.flush = 1'b0; apply(s);
        end
        s = rand_stim(); s.rst = 1'b1; s.stall = 1'b1; s.flush = 1'b1; apply(s);
        s = base(2'd0, 5'd10); s.alu = 32'hCAFE_0001; apply(s);

        for (int i = 0; i < 400; i++) begin
            apply(rand_stim());
        end

        repeat (3) @(negedge clk);
        chk("queue_drain", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
